reg_file_1wp: RTL and testbench
===============================

REG_FILE_1WP -- requirements
Module: reg_file_1wp

Interface
REQ-001 Parameters: none; data width fixed at 16 bits, register count fixed at 8 (3-bit address).
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 w_valid_in  in  1  write request.
REQ-005 w_ready_out  out  1  write port can accept.
REQ-006 w_addr_in  in  3  write register index.
REQ-007 w_data_in  in  16  write data.
REQ-008 w_be_in  in  2  byte enables; bit 1 = bits 15:8, bit 0 = bits 7:0.
REQ-009 c_out  out  128  packed image of all registers; register i on bits 16*(7-i)+15 downto 16*(7-i), so register 0 occupies bits 127:112.
REQ-010 dump_start_in  in  1  request serial dump of all registers.
REQ-011 dump_busy_out  out  1  dump in progress.
REQ-012 dump_valid_out  out  1  dump beat valid.
REQ-013 dump_addr_out  out  3  index of current dump beat.
REQ-014 dump_data_out  out  16  register contents for current dump beat.
REQ-015 dump_ready_in  in  1  dump consumer accepts beat.

Function
REQ-016 Storage: 8 x 16-bit registers, one write port, no other write path.
REQ-017 Write accepted at a rising edge when w_valid_in = 1 and w_ready_out = 1; accepted bytes with w_be_in bit set are updated at that edge; unselected bytes are held.
REQ-018 w_be_in = 00 with handshake: accepted, no register change.
REQ-019 c_out is combinational from the register array; an accepted write is visible on c_out in the cycle after the accepting edge.
REQ-020 w_ready_out = 1 exactly when FSM is IDLE; writes presented while not ready are ignored and not queued.
REQ-021 Dump FSM states: IDLE, SEND.
REQ-022 IDLE -> SEND when dump_start_in = 1 at an edge; dump index loads 0.
REQ-023 In SEND: dump_busy_out = 1, dump_valid_out = 1, dump_addr_out = index, dump_data_out = register[index]; all held stable until handshake.
REQ-024 Beat handshake: dump_valid_out = 1 and dump_ready_in = 1 at an edge; index increments by 1.
REQ-025 Handshake with index = 7: SEND -> IDLE, index returns to 0; no wrap into a second pass.
REQ-026 In IDLE: dump_busy_out = 0, dump_valid_out = 0, dump_addr_out = 0, dump_data_out = 0.
REQ-027 dump_start_in while in SEND is ignored; no restart, no queued second dump.
REQ-028 Same-edge write and dump_start_in in IDLE: write is applied and the dump starts; the dump reports the written value.
REQ-029 Back-to-back: dump_start_in asserted on the edge that completes the final beat is ignored (FSM still SEND at that edge).
REQ-030 Latency: with dump_ready_in held 1, a dump is 8 cycles of dump_valid_out; w_ready_out returns 1 in the cycle after the 8th handshake.
REQ-031 dump_ready_in with dump_valid_out = 0 has no effect.

Reset
REQ-032 With reset = 1 at an edge: all registers 0, FSM IDLE, index 0; reset overrides any write or dump_start_in on the same edge.
REQ-033 After reset: c_out = 0, w_ready_out = 1, dump_busy_out = 0, dump_valid_out = 0, dump_addr_out = 0, dump_data_out = 0.
REQ-034 Reset during SEND aborts the dump immediately; no further beats are produced.

Verification
REQ-035 Reset, then write addr 0 = 0xA5A5 and addr 7 = 0x1234 with be = 11 -> c_out[127:112] = 0xA5A5, c_out[15:0] = 0x1234, all other bits 0.
REQ-036 Write addr 3 = 0xFFFF (be = 11), then addr 3 = 0x0000 with be = 01 -> register 3 = 0xFF00; then be = 00 with data 0x1111 -> still 0xFF00.
REQ-037 Load reg i = 0x0100*i + i, dump with dump_ready_in = 1 -> 8 consecutive beats, addr 0..7, data 0x0000, 0x0101, ... 0x0707; busy drops after the 8th beat.
REQ-038 Dump with dump_ready_in toggling 1,0,0,1,... -> each beat held stable while ready = 0, no beat skipped or duplicated; writes during dump see w_ready_out = 0 and leave c_out unchanged.
REQ-039 Same edge: write addr 0 = 0xBEEF and dump_start_in -> first beat addr 0, data 0xBEEF.
REQ-040 Reset asserted on 3rd beat of a dump -> next cycle dump_valid_out = 0, w_ready_out = 1, c_out = 0; dump_start_in mid-dump has no effect.

Source files
------------

// File: rtl/reg_file_1wp.sv
// Purpose: 8 x 16-bit register file with one byte-enabled write port, a flat image output and a serial dump port.
// Latency: a write shows on c_out the cycle after it is accepted; dump beats come one per cycle while dump_ready_in is high.
// Backpressure: writes are stalled (w_ready_out = 0) for the whole dump; each dump beat holds until dump_ready_in.
//
// Ports:
//   clock, reset                       single clock, synchronous active-high reset
//   w_valid_in/w_ready_out             write handshake
//   w_addr_in, w_data_in, w_be_in      write index, data, byte enables (bit 1 = 15:8, bit 0 = 7:0)
//   c_out                              packed image, register 0 in bits 127:112 down to register 7 in 15:0
//   dump_start_in                      start a serial dump of all registers (ignored while dumping)
//   dump_busy_out, dump_valid_out      dump status / beat valid
//   dump_addr_out, dump_data_out       current beat index and register contents
//   dump_ready_in                      consumer accepts the current beat
module reg_file_1wp (
  input  logic         clock,
  input  logic         reset,
  input  logic         w_valid_in,
  output logic         w_ready_out,
  input  logic [2:0]   w_addr_in,
  input  logic [15:0]  w_data_in,
  input  logic [1:0]   w_be_in,
  output logic [127:0] c_out,
  input  logic         dump_start_in,
  output logic         dump_busy_out,
  output logic         dump_valid_out,
  output logic [2:0]   dump_addr_out,
  output logic [15:0]  dump_data_out,
  input  logic         dump_ready_in
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state;
  logic [2:0]  idx;
  logic [15:0] regs [0:7];
  logic        w_accept;

  // The write port is only open while no dump is running, so the dump
  // always reports a consistent snapshot.
  assign w_ready_out = (state == IDLE);
  assign w_accept    = w_valid_in && w_ready_out;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (w_accept) begin
      if (w_be_in[1]) regs[w_addr_in][15:8] <= w_data_in[15:8];
      if (w_be_in[0]) regs[w_addr_in][7:0]  <= w_data_in[7:0];
    end
  end

  // Dump sequencer: walks index 0..7 once, advancing on each accepted beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dump_start_in) begin
            state <= SEND;
            idx   <= '0;
          end
        end
        SEND: begin
          if (dump_ready_in) begin
            if (idx == 3'd7) begin
              state <= IDLE;
              idx   <= '0;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  // Dump outputs decode straight from the state/index flops. The data mux
  // reads the live array; a write landing on the start edge is already in
  // regs when the first beat is shown, and no write can occur during SEND.
  assign dump_busy_out  = (state == SEND);
  assign dump_valid_out = (state == SEND);
  assign dump_addr_out  = (state == SEND) ? idx : 3'd0;
  assign dump_data_out  = (state == SEND) ? regs[idx] : 16'h0000;

  always_comb begin
    c_out = '0;
    for (int i = 0; i < 8; i++) c_out[16*(7-i) +: 16] = regs[i];
  end

endmodule

// File: tb/tb_reg_file_1wp.sv
module tb_reg_file_1wp;

  logic         clock = 1'b0;
  logic         reset;
  logic         w_valid_in;
  logic         w_ready_out;
  logic [2:0]   w_addr_in;
  logic [15:0]  w_data_in;
  logic [1:0]   w_be_in;
  logic [127:0] c_out;
  logic         dump_start_in;
  logic         dump_busy_out;
  logic         dump_valid_out;
  logic [2:0]   dump_addr_out;
  logic [15:0]  dump_data_out;
  logic         dump_ready_in;

  int errors = 0;
  int checks = 0;

  logic [15:0] model [0:7];
  logic [18:0] exp_q [$];

  reg_file_1wp dut (
    .clock          (clock),
    .reset          (reset),
    .w_valid_in     (w_valid_in),
    .w_ready_out    (w_ready_out),
    .w_addr_in      (w_addr_in),
    .w_data_in      (w_data_in),
    .w_be_in        (w_be_in),
    .c_out          (c_out),
    .dump_start_in  (dump_start_in),
    .dump_busy_out  (dump_busy_out),
    .dump_valid_out (dump_valid_out),
    .dump_addr_out  (dump_addr_out),
    .dump_data_out  (dump_data_out),
    .dump_ready_in  (dump_ready_in)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] image();
    logic [127:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c[16*(7-i) +: 16] = model[i];
    return c;
  endfunction

  task automatic write(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
    w_valid_in = 1'b1;
    w_addr_in  = a;
    w_data_in  = d;
    w_be_in    = be;
    tick();
    w_valid_in = 1'b0;
    if (be[1]) model[a][15:8] = d[15:8];
    if (be[0]) model[a][7:0]  = d[7:0];
  endtask

  task automatic push_all();
    for (int i = 0; i < 8; i++) begin
      logic [2:0] a;
      a = i[2:0];
      exp_q.push_back({a, model[i]});
    end
  endtask

  // Drives dump_ready_in per cycle (mode 0: always 1, mode 1: 1,0,0,1,0,0...),
  // checks each presented beat against the queue head and pops on handshake.
  // With traffic set, writes and dump_start_in are held high throughout.
  // With reset_at >= 0, reset is raised when that beat is presented.
  task automatic run_dump(input int mode, input bit traffic, input int reset_at,
                          output int valid_cycles);
    int cyc;
    int beats;
    logic [18:0] e;
    cyc = 0;
    beats = 0;
    valid_cycles = 0;
    while (cyc < 60) begin
      dump_ready_in = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (traffic) begin
        w_valid_in    = 1'b1;
        w_addr_in     = cyc[2:0];
        w_data_in     = 16'hDEAD;
        w_be_in       = 2'b11;
        dump_start_in = 1'b1;
      end
      if (!dump_valid_out) break;
      valid_cycles++;
      chk("busy_in_dump", {127'b0, dump_busy_out}, 128'd1);
      chk("wready_in_dump", {127'b0, w_ready_out}, 128'd0);
      if (reset_at >= 0 && beats == reset_at) begin
        reset = 1'b1;
        break;
      end
      if (exp_q.size() == 0) begin
        chk("extra_beat", 128'd1, 128'd0);
        break;
      end
      e = exp_q[0];
      chk("beat_addr", {125'b0, dump_addr_out}, {125'b0, e[18:16]});
      chk("beat_data", {112'b0, dump_data_out}, {112'b0, e[15:0]});
      if (dump_ready_in) begin
        void'(exp_q.pop_front());
        beats++;
      end
      tick();
      cyc++;
    end
    if (cyc >= 60) chk("dump_timeout", 128'd1, 128'd0);
    w_valid_in    = 1'b0;
    dump_start_in = 1'b0;
    dump_ready_in = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_wready"}, {127'b0, w_ready_out},    128'd1);
    chk({tag, "_busy"},   {127'b0, dump_busy_out},  128'd0);
    chk({tag, "_valid"},  {127'b0, dump_valid_out}, 128'd0);
    chk({tag, "_addr"},   {125'b0, dump_addr_out},  128'd0);
    chk({tag, "_data"},   {112'b0, dump_data_out},  128'd0);
  endtask

  initial begin
    int vc;
    reset         = 1'b1;
    w_valid_in    = 1'b0;
    w_addr_in     = '0;
    w_data_in     = '0;
    w_be_in       = '0;
    dump_start_in = 1'b0;
    dump_ready_in = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = '0;

    // Reset overrides a simultaneous write and dump start.
    tick();
    w_valid_in    = 1'b1;
    w_addr_in     = 3'd2;
    w_data_in     = 16'hFFFF;
    w_be_in       = 2'b11;
    dump_start_in = 1'b1;
    tick();
    w_valid_in    = 1'b0;
    dump_start_in = 1'b0;
    chk("reset_c_out", c_out, 128'd0);
    check_idle_outputs("reset");
    reset = 1'b0;
    tick();

    // Full-word writes to the two end registers.
    write(3'd0, 16'hA5A5, 2'b11);
    write(3'd7, 16'h1234, 2'b11);
    chk("c_out_ends", c_out, {16'hA5A5, 96'b0, 16'h1234});

    // Byte enables.
    write(3'd3, 16'hFFFF, 2'b11);
    chk("reg3_full", c_out, image());
    write(3'd3, 16'h0000, 2'b01);
    chk("reg3_lo_byte", {112'b0, c_out[64 +: 16]}, {112'b0, 16'hFF00});
    write(3'd3, 16'h1111, 2'b00);
    chk("reg3_be00", {112'b0, c_out[64 +: 16]}, {112'b0, 16'hFF00});
    chk("image_after_be", c_out, image());

    // Load i*0x0101, dump with ready held high.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] a;
      a = i[2:0];
      write(a, {5'b0, a, 5'b0, a}, 2'b11);
    end
    chk("image_loaded", c_out, image());
    // Ready without a valid beat must not disturb anything.
    dump_ready_in = 1'b1;
    tick();
    tick();
    check_idle_outputs("ready_idle");
    push_all();
    dump_start_in = 1'b1;
    tick();
    dump_start_in = 1'b0;
    run_dump(0, 1'b0, -1, vc);
    chk("dump1_len", vc, 8);
    chk("dump1_drained", exp_q.size(), 0);
    check_idle_outputs("dump1_end");

    // Toggling ready, with writes and dump_start held during the dump,
    // including on the final handshake edge.
    push_all();
    dump_start_in = 1'b1;
    tick();
    dump_start_in = 1'b0;
    run_dump(1, 1'b1, -1, vc);
    chk("dump2_drained", exp_q.size(), 0);
    chk("dump2_image_kept", c_out, image());
    check_idle_outputs("dump2_end");

    // Same-edge write and dump start: first beat reports the new value.
    dump_start_in = 1'b1;
    write(3'd0, 16'hBEEF, 2'b11);
    dump_start_in = 1'b0;
    push_all();
    run_dump(0, 1'b0, -1, vc);
    chk("dump3_len", vc, 8);
    chk("dump3_drained", exp_q.size(), 0);

    // Reset on the third beat, with a mid-dump start request.
    push_all();
    dump_start_in = 1'b1;
    tick();
    dump_start_in = 1'b0;
    run_dump(0, 1'b1, 2, vc);
    tick();
    chk("abort_valid", {127'b0, dump_valid_out}, 128'd0);
    chk("abort_wready", {127'b0, w_ready_out}, 128'd1);
    chk("abort_c_out", c_out, 128'd0);
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) model[i] = '0;
    dump_ready_in = 1'b1;
    tick();
    tick();
    check_idle_outputs("after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
